// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: top-level game sequencer for the snake game.
// Produces the periodic move step, turns collision flags sampled on a step
// into one-cycle score pulses, and runs the IDLE/RUN/PAUSE/OVER state machine.
module snake_game_ctrl #(
    parameter int STEP_DIV = 4,
    parameter int CNT_W    = 24
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       startBtn,
    input  logic       pauseBtn,
    input  logic       appleHit,
    input  logic       wallHit,
    input  logic       selfHit,
    input  logic       isGameComplete,
    output logic       moveStep,
    output logic       goodColl,
    output logic       badColl,
    output logic       spawnApple,
    output logic       clearBoard,
    output logic       gameOver,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             good_r;
    logic             bad_r;
    logic             spawn_r;
    logic             clear_r;

    logic             move_step_s;
    logic             step_fatal_s;
    logic             step_apple_s;

    // Step strobe depends only on registers, so it is glitch-free for the board datapath.
    assign move_step_s  = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
    // A fatal collision on a step overrides an apple on the same step.
    assign step_fatal_s = move_step_s && (wallHit || selfHit);
    assign step_apple_s = move_step_s && appleHit && !(wallHit || selfHit);

    // Game state machine, step counter and single-cycle pulse registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            good_r  <= 1'b0;
            bad_r   <= 1'b0;
            spawn_r <= 1'b0;
            clear_r <= 1'b0;
        end else begin
            // Pulses default low so none can last longer than one cycle.
            good_r  <= 1'b0;
            bad_r   <= 1'b0;
            spawn_r <= 1'b0;
            clear_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (startBtn) begin
                        state_r <= ST_RUN;
                        cnt_r   <= CNT_ZERO;
                        clear_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // The counter runs on every RUN cycle, including the one leaving RUN.
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                    if (step_fatal_s) begin
                        bad_r   <= 1'b1;
                        state_r <= ST_OVER;
                    end else begin
                        good_r  <= step_apple_s;
                        spawn_r <= step_apple_s;
                        // A won game ends the run without a fatal pulse.
                        if (isGameComplete) begin
                            state_r <= ST_OVER;
                        end else if (pauseBtn) begin
                            state_r <= ST_PAUSE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_PAUSE: begin
                    // Counter holds so the step phase resumes where it left off.
                    if (pauseBtn) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                ST_OVER: begin
                    if (startBtn) begin
                        state_r <= ST_RUN;
                        cnt_r   <= CNT_ZERO;
                        clear_r <= 1'b1;
                    end else begin
                        state_r <= ST_OVER;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign moveStep   = move_step_s;
    assign goodColl   = good_r;
    assign badColl    = bad_r;
    assign spawnApple = spawn_r;
    assign clearBoard = clear_r;
    assign gameOver   = (state_r == ST_OVER);
    assign state      = state_r;

endmodule
